// File: rtl/alarm_controller.sv
// Multi-channel BCD alarm controller with ring timeout, dismiss and 1 Hz buzzer beat.
// Optional snooze support is built when ALARM_SNOOZE_EN is defined.
module alarm_controller #(
    parameter int N_ALARMS    = 2,
    parameter int NDIGITS     = 4,
    parameter int RING_SECS   = 60,
    parameter int SNOOZE_SECS = 300,
    parameter int IDW         = 1
) (
    input  logic                          uclock,
    input  logic                          reset,
    input  logic                          tick_1hz,
    input  logic [4*NDIGITS-1:0]          time_digits,
    input  logic [N_ALARMS*4*NDIGITS-1:0] alarm_digits,
    input  logic [N_ALARMS-1:0]           alarm_enable,
    input  logic                          dismiss,
    input  logic                          snooze,
    output logic [N_ALARMS-1:0]           alarm_status,
    output logic                          alarm_ring,
    output logic [IDW-1:0]                ring_id,
    output logic                          buzzer
);

    localparam int TW = 4*NDIGITS;
    localparam int RW = (RING_SECS > 1) ? $clog2(RING_SECS) : 1;
    localparam logic [RW-1:0] RING_LAST = RW'(RING_SECS-1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RING = 2'd1,
        ST_SNZ  = 2'd2
    } state_t;

    state_t        r_state        [N_ALARMS];
    state_t        w_state_nxt    [N_ALARMS];
    logic [RW-1:0] r_ring_cnt     [N_ALARMS];
    logic [RW-1:0] w_ring_cnt_nxt [N_ALARMS];

`ifdef ALARM_SNOOZE_EN
    localparam int SW = (SNOOZE_SECS > 1) ? $clog2(SNOOZE_SECS) : 1;
    localparam logic [SW-1:0] SNZ_LAST = SW'(SNOOZE_SECS-1);
    logic [SW-1:0] r_snz_cnt     [N_ALARMS];
    logic [SW-1:0] w_snz_cnt_nxt [N_ALARMS];
`else
    logic w_unused_snooze;
    assign w_unused_snooze = snooze;
`endif

    logic [N_ALARMS-1:0] r_match_prev;
    logic [N_ALARMS-1:0] w_match;
    logic [N_ALARMS-1:0] w_trig;
    logic [N_ALARMS-1:0] w_ring_cur;
    logic [N_ALARMS-1:0] w_ring_nxt;
    logic                r_beat;
    logic                w_beat_nxt;
    logic [IDW-1:0]      w_id_nxt;

    always_comb begin
        for (int i = 0; i < N_ALARMS; i++) begin
            w_match[i] = alarm_status[i] &&
                         (alarm_digits[i*TW +: TW] == time_digits);
            w_trig[i]  = w_match[i] && !r_match_prev[i];
        end
    end

    // Next-state per channel; the case order encodes the priority chain.
    always_comb begin
        for (int i = 0; i < N_ALARMS; i++) begin
            w_state_nxt[i]    = r_state[i];
            w_ring_cnt_nxt[i] = r_ring_cnt[i];
`ifdef ALARM_SNOOZE_EN
            w_snz_cnt_nxt[i]  = r_snz_cnt[i];
`endif
            if (!alarm_status[i]) begin
                w_state_nxt[i] = ST_IDLE;
            end else begin
                case (r_state[i])
                    ST_IDLE: begin
                        if (w_trig[i]) begin
                            w_state_nxt[i]    = ST_RING;
                            w_ring_cnt_nxt[i] = '0;
                        end
                    end
                    ST_RING: begin
                        if (dismiss) begin
                            w_state_nxt[i] = ST_IDLE;
`ifdef ALARM_SNOOZE_EN
                        end else if (snooze) begin
                            w_state_nxt[i]   = ST_SNZ;
                            w_snz_cnt_nxt[i] = '0;
`endif
                        end else if (tick_1hz) begin
                            if (r_ring_cnt[i] == RING_LAST)
                                w_state_nxt[i] = ST_IDLE;
                            else
                                w_ring_cnt_nxt[i] = r_ring_cnt[i] + 1'b1;
                        end
                    end
`ifdef ALARM_SNOOZE_EN
                    ST_SNZ: begin
                        if (dismiss) begin
                            w_state_nxt[i] = ST_IDLE;
                        end else if (tick_1hz) begin
                            if (r_snz_cnt[i] == SNZ_LAST) begin
                                w_state_nxt[i]    = ST_RING;
                                w_ring_cnt_nxt[i] = '0;
                            end else begin
                                w_snz_cnt_nxt[i] = r_snz_cnt[i] + 1'b1;
                            end
                        end
                    end
`endif
                    default: w_state_nxt[i] = ST_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        w_id_nxt = '0;
        for (int i = 0; i < N_ALARMS; i++) begin
            w_ring_cur[i] = (r_state[i] == ST_RING);
            w_ring_nxt[i] = (w_state_nxt[i] == ST_RING);
        end
        for (int i = N_ALARMS-1; i >= 0; i--) begin
            if (w_ring_nxt[i])
                w_id_nxt = IDW'(i);
        end
        if (!(|w_ring_cur))
            w_beat_nxt = 1'b0;
        else
            w_beat_nxt = tick_1hz ? !r_beat : r_beat;
    end

    always_ff @(posedge uclock) begin
        if (reset) begin
            for (int i = 0; i < N_ALARMS; i++) begin
                r_state[i]    <= ST_IDLE;
                r_ring_cnt[i] <= '0;
`ifdef ALARM_SNOOZE_EN
                r_snz_cnt[i]  <= '0;
`endif
            end
            r_match_prev <= '0;
            r_beat       <= 1'b0;
            alarm_status <= '0;
            alarm_ring   <= 1'b0;
            ring_id      <= '0;
            buzzer       <= 1'b0;
        end else begin
            for (int i = 0; i < N_ALARMS; i++) begin
                r_state[i]    <= w_state_nxt[i];
                r_ring_cnt[i] <= w_ring_cnt_nxt[i];
`ifdef ALARM_SNOOZE_EN
                r_snz_cnt[i]  <= w_snz_cnt_nxt[i];
`endif
            end
            r_match_prev <= w_match;
            r_beat       <= w_beat_nxt;
            alarm_status <= alarm_enable;
            alarm_ring   <= |w_ring_nxt;
            ring_id      <= w_id_nxt;
            buzzer       <= (|w_ring_nxt) && w_beat_nxt;
        end
    end

endmodule

// File: tb/tb_alarm_controller.sv
// Table-driven scoreboard bench for alarm_controller.
// N_ALARMS=2, NDIGITS=4, RING_SECS=3, SNOOZE_SECS=2.
module tb_alarm_controller;

    logic        uclock = 1'b0;
    logic        reset;
    logic        tick_1hz;
    logic [15:0] time_digits;
    logic [31:0] alarm_digits;
    logic [1:0]  alarm_enable;
    logic        dismiss;
    logic        snooze;
    logic [1:0]  alarm_status;
    logic        alarm_ring;
    logic [0:0]  ring_id;
    logic        buzzer;

    alarm_controller #(
        .N_ALARMS(2), .NDIGITS(4), .RING_SECS(3),
        .SNOOZE_SECS(2), .IDW(1)
    ) dut (
        .uclock(uclock), .reset(reset), .tick_1hz(tick_1hz),
        .time_digits(time_digits), .alarm_digits(alarm_digits),
        .alarm_enable(alarm_enable), .dismiss(dismiss), .snooze(snooze),
        .alarm_status(alarm_status), .alarm_ring(alarm_ring),
        .ring_id(ring_id), .buzzer(buzzer)
    );

    always #5 uclock = ~uclock;

    typedef struct packed {
        logic        rst;
        logic        tick;
        logic [15:0] tm;
        logic [1:0]  en;
        logic        dis;
        logic        snz;
        logic [4:0]  exp;
    } vec_t;

    vec_t       tbl [34];
    logic [4:0] exp_q [$];
    int         checks = 0;
    int         errors = 0;
    string      tag;

    function automatic vec_t v(input logic r, input logic t,
                               input logic [15:0] tm,
                               input logic [1:0] en,
                               input logic d, input logic s,
                               input logic [1:0] st, input logic rg,
                               input logic id, input logic bz);
        vec_t x;
        x.rst = r; x.tick = t; x.tm = tm; x.en = en;
        x.dis = d; x.snz = s;
        x.exp = {st, rg, id, bz};
        return x;
    endfunction

    task automatic apply(input vec_t x);
        logic [4:0] e;
        logic [4:0] got;
        reset        = x.rst;
        tick_1hz     = x.tick;
        time_digits  = x.tm;
        alarm_enable = x.en;
        dismiss      = x.dis;
        snooze       = x.snz;
        exp_q.push_back(x.exp);
        @(posedge uclock);
        #1;
        e   = exp_q.pop_front();
        got = {alarm_status, alarm_ring, ring_id, buzzer};
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL %s: {status,ring,id,buzz} got %b required %b",
                     tag, got, e);
        end
    endtask

    initial begin
        reset = 1'b1; tick_1hz = 1'b0; time_digits = 16'h0659;
        alarm_enable = 2'b00; dismiss = 1'b0; snooze = 1'b0;
        alarm_digits = {16'h0730, 16'h0700};

        tbl[0]  = v(0,0,16'h0659,2'b11,0,0, 2'b11,0,0,0);
        tbl[1]  = v(0,0,16'h0659,2'b11,0,0, 2'b11,0,0,0);
        tbl[2]  = v(0,0,16'h0700,2'b11,0,0, 2'b11,1,0,0);
        tbl[3]  = v(0,0,16'h0700,2'b11,0,0, 2'b11,1,0,0);
        tbl[4]  = v(0,1,16'h0700,2'b11,0,0, 2'b11,1,0,1);
        tbl[5]  = v(0,0,16'h0700,2'b11,0,0, 2'b11,1,0,1);
        tbl[6]  = v(0,0,16'h0700,2'b11,0,0, 2'b11,1,0,1);
        tbl[7]  = v(0,0,16'h0700,2'b11,0,0, 2'b11,1,0,1);
        tbl[8]  = v(0,1,16'h0700,2'b11,0,0, 2'b11,1,0,0);
        tbl[9]  = v(0,0,16'h0700,2'b11,0,0, 2'b11,1,0,0);
        tbl[10] = v(0,0,16'h0700,2'b11,0,0, 2'b11,1,0,0);
        tbl[11] = v(0,0,16'h0700,2'b11,0,0, 2'b11,1,0,0);
        tbl[12] = v(0,1,16'h0700,2'b11,0,0, 2'b11,0,0,0);
        tbl[13] = v(0,0,16'h0700,2'b11,0,0, 2'b11,0,0,0);
        tbl[14] = v(0,0,16'h0701,2'b11,0,0, 2'b11,0,0,0);
        tbl[15] = v(0,0,16'h0700,2'b11,0,0, 2'b11,1,0,0);
        tbl[16] = v(0,0,16'h0700,2'b11,1,0, 2'b11,0,0,0);
        tbl[17] = v(0,0,16'h0700,2'b11,0,0, 2'b11,0,0,0);
        tbl[18] = v(0,0,16'h0700,2'b11,0,0, 2'b11,0,0,0);
        tbl[19] = v(0,0,16'h0701,2'b11,0,0, 2'b11,0,0,0);
        tbl[20] = v(0,0,16'h0700,2'b11,1,0, 2'b11,1,0,0);
        tbl[21] = v(0,0,16'h0700,2'b11,0,0, 2'b11,1,0,0);
        tbl[22] = v(0,0,16'h0700,2'b10,0,0, 2'b10,1,0,0);
        tbl[23] = v(0,0,16'h0700,2'b10,0,0, 2'b10,0,0,0);
        tbl[24] = v(0,0,16'h0700,2'b10,0,0, 2'b10,0,0,0);
        tbl[25] = v(0,0,16'h0700,2'b11,0,0, 2'b11,0,0,0);
        tbl[26] = v(0,0,16'h0700,2'b11,0,0, 2'b11,1,0,0);
        tbl[27] = v(0,0,16'h0700,2'b11,1,0, 2'b11,0,0,0);
        tbl[28] = v(0,0,16'h0700,2'b11,0,0, 2'b11,0,0,0);
        tbl[29] = v(0,0,16'h0730,2'b11,0,0, 2'b11,1,1,0);
        tbl[30] = v(0,1,16'h0730,2'b11,0,0, 2'b11,1,1,1);
        tbl[31] = v(0,0,16'h0700,2'b11,0,0, 2'b11,1,0,1);
        tbl[32] = v(0,0,16'h0700,2'b11,1,0, 2'b11,0,0,0);
        tbl[33] = v(0,0,16'h0700,2'b11,0,0, 2'b11,0,0,0);

        tag = "reset";
        apply(v(1,0,16'h0659,2'b11,0,0, 2'b00,0,0,0));
        apply(v(1,0,16'h0659,2'b11,0,0, 2'b00,0,0,0));

        for (int i = 0; i < 34; i++) begin
            tag = $sformatf("vec%0d", i);
            apply(tbl[i]);
        end

        // both channels on the same minute
        alarm_digits = {16'h0700, 16'h0700};
        tag = "both_pre";   apply(v(0,0,16'h0659,2'b11,0,0, 2'b11,0,0,0));
        tag = "both_trig";  apply(v(0,0,16'h0700,2'b11,0,0, 2'b11,1,0,0));
        tag = "both_dis";   apply(v(0,0,16'h0700,2'b11,1,0, 2'b11,0,0,0));
        tag = "both_hold";  apply(v(0,0,16'h0700,2'b11,0,0, 2'b11,0,0,0));
        tag = "both_0701";  apply(v(0,0,16'h0701,2'b11,0,0, 2'b11,0,0,0));
        tag = "both_retrg"; apply(v(0,0,16'h0700,2'b11,0,0, 2'b11,1,0,0));
        tag = "dis0_e1";    apply(v(0,0,16'h0700,2'b10,0,0, 2'b10,1,0,0));
        tag = "dis0_e2";    apply(v(0,0,16'h0700,2'b10,0,0, 2'b10,1,1,0));
        tag = "mid_reset";  apply(v(1,0,16'h0700,2'b11,0,0, 2'b00,0,0,0));
        tag = "post_reset"; apply(v(0,0,16'h0659,2'b11,0,0, 2'b11,0,0,0));

        alarm_digits = {16'h0730, 16'h0700};
        tag = "snz_pre";  apply(v(0,0,16'h0659,2'b11,0,0, 2'b11,0,0,0));
        tag = "snz_trig"; apply(v(0,0,16'h0700,2'b11,0,0, 2'b11,1,0,0));
`ifdef ALARM_SNOOZE_EN
        tag = "snz_on";   apply(v(0,0,16'h0700,2'b11,0,1, 2'b11,0,0,0));
        for (int k = 0; k < 8; k++) begin
            tag = $sformatf("snz_wait%0d", k);
            apply(v(0, (k == 3 || k == 7), 16'h0700, 2'b11, 0, 0,
                    2'b11, (k == 7), 0, 0));
        end
        tag = "snz_again"; apply(v(0,0,16'h0700,2'b11,0,1, 2'b11,0,0,0));
        tag = "snz_dis";   apply(v(0,0,16'h0700,2'b11,1,0, 2'b11,0,0,0));
        for (int k = 0; k < 8; k++) begin
            tag = $sformatf("snz_dead%0d", k);
            apply(v(0, (k == 3 || k == 7), 16'h0700, 2'b11, 0, 0,
                    2'b11, 0, 0, 0));
        end
`else
        tag = "snz_ign";   apply(v(0,0,16'h0700,2'b11,0,1, 2'b11,1,0,0));
        tag = "snz_ign_t"; apply(v(0,1,16'h0700,2'b11,0,1, 2'b11,1,0,1));
        tag = "snz_dis";   apply(v(0,0,16'h0700,2'b11,1,0, 2'b11,0,0,0));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

endmodule
